// File: rtl/registrador_universal_n_if.sv
// Command/status bus of the multi-mode register: control unit drives commands,
// register returns q and the busy/done handshake.
interface registrador_universal_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             clear;
  logic             start;
  logic             ch1;
  logic             ch0;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] valores_registrador;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output clear, start, ch1, ch0, amount, valores_registrador, serial_in,
    input  q, busy, done
  );

  modport slave (
    input  clear, start, ch1, ch0, amount, valores_registrador, serial_in,
    output q, busy, done
  );
endinterface

// File: rtl/registrador_universal_n.sv
// WIDTH-bit register with hold, parallel load, serial right shift and
// OR-feedback rotate; shifts run for a programmed amount under a small FSM.
module registrador_universal_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  registrador_universal_n_if.slave bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [AMT_W-1:0] r_cnt;
  logic             r_or_fb;  // latched mode LSB: 1 = OR-feedback rotate
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;

  logic [1:0] w_mode;
  logic       w_msb;

  assign w_mode = {bus.ch1, bus.ch0};
  // Bit falling off position 0 re-enters at the MSB only in rotate mode.
  assign w_msb  = bus.serial_in | (r_or_fb & r_q[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_or_fb <= 1'b0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_q     <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              case (w_mode)
                2'b00: r_done <= 1'b1;
                2'b01: begin
                  r_q    <= bus.valores_registrador;
                  r_done <= 1'b1;
                end
                default: begin
                  if (bus.amount == '0) begin
                    r_done <= 1'b1;
                  end else begin
                    r_or_fb <= w_mode[0];
                    r_cnt   <= bus.amount;
                    r_busy  <= 1'b1;
                    r_state <= S_SHIFT;
                  end
                end
              endcase
            end
          end
          S_SHIFT: begin
            r_q   <= {w_msb, r_q[WIDTH-1:1]};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == AMT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_registrador_universal_n.sv
// Bench for registrador_universal_n: directed vector table, hand-written
// reset/collision sequences, then random traffic against a reference model.
module tb_registrador_universal_n;
  localparam int W = 8;
  localparam int A = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  registrador_universal_n_if #(.WIDTH(W), .AMT_W(A)) bus ();

  registrador_universal_n #(.WIDTH(W), .AMT_W(A)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         st;
    logic [1:0]   ch;
    logic [A-1:0] amt;
    logic [W-1:0] val;
    logic         sin;
    logic [W-1:0] eq;
    logic         eb;
    logic         ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic clr, logic st, logic [1:0] ch, logic [A-1:0] amt,
                              logic [W-1:0] val, logic sin, logic [W-1:0] eq,
                              logic eb, logic ed);
    vec_t v;
    v.clr = clr; v.st = st; v.ch = ch; v.amt = amt; v.val = val; v.sin = sin;
    v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic st, input logic [1:0] ch,
                       input logic [A-1:0] amt, input logic [W-1:0] val, input logic sin);
    bus.clear = clr; bus.start = st; bus.ch1 = ch[1]; bus.ch0 = ch[0];
    bus.amount = amt; bus.valores_registrador = val; bus.serial_in = sin;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string nm, input logic [W-1:0] eq, input logic eb, input logic ed);
    chk({nm, ".q"},    32'(bus.q),    32'(eq));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(eb));
    chk({nm, ".done"}, 32'(bus.done), 32'(ed));
  endtask

  // Reference model: q as a number, pending work as a count of remaining steps.
  logic [W-1:0] m_q;
  int           m_left;
  logic         m_or;
  logic         m_done;

  task automatic model_edge(input logic clr, input logic st, input logic [1:0] ch,
                            input logic [A-1:0] amt, input logic [W-1:0] val, input logic sin);
    logic msb;
    m_done = 1'b0;
    if (clr) begin
      m_q = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      msb = sin | (m_or & m_q[0]);
      m_q = W'(m_q / 2) + (msb ? W'(1 << (W-1)) : W'(0));
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (st) begin
      if (ch == 2'b01) m_q = val;
      if (ch[1] && amt != 0) begin
        m_left = int'(amt);
        m_or   = ch[0];
      end else begin
        m_done = 1'b1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk3("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: one edge per record, from q=0.
    tbl.push_back(mk(0,1,2'b01,4'd0,8'hA5,0, 8'hA5,0,1));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'hA5,0,0));
    tbl.push_back(mk(0,1,2'b10,4'd3,8'h00,1, 8'hA5,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hD2,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hE9,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hF4,0,1));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'hF4,0,0));
    tbl.push_back(mk(0,1,2'b01,4'd0,8'h01,0, 8'h01,0,1));
    tbl.push_back(mk(0,1,2'b11,4'd1,8'h00,0, 8'h01,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h80,0,1));
    tbl.push_back(mk(0,1,2'b01,4'd0,8'h81,0, 8'h81,0,1));
    tbl.push_back(mk(0,1,2'b11,4'd8,8'h00,0, 8'h81,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'hC0,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h60,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h30,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h18,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h0C,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h06,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h03,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,0, 8'h81,0,1));
    tbl.push_back(mk(0,1,2'b01,4'd0,8'h00,0, 8'h00,0,1));
    tbl.push_back(mk(0,1,2'b11,4'd8,8'h00,1, 8'h00,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'h80,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hC0,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hE0,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hF0,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hF8,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hFC,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hFE,1,0));
    tbl.push_back(mk(0,0,2'b00,4'd0,8'h00,1, 8'hFF,0,1));
    tbl.push_back(mk(0,1,2'b01,4'd0,8'h3C,0, 8'h3C,0,1));
    tbl.push_back(mk(0,1,2'b10,4'd0,8'hFF,1, 8'h3C,0,1));
    tbl.push_back(mk(0,1,2'b00,4'd5,8'hFF,1, 8'h3C,0,1));
    tbl.push_back(mk(0,1,2'b11,4'd0,8'hFF,1, 8'h3C,0,1));
    tbl.push_back(mk(0,0,2'b10,4'd5,8'hFF,1, 8'h3C,0,0));
    tbl.push_back(mk(1,1,2'b01,4'd0,8'hFF,1, 8'h00,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].st, tbl[i].ch, tbl[i].amt, tbl[i].val, tbl[i].sin);
      tick();
      chk3($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed);
    end

    // Asynchronous reset in the middle of a shift.
    drive(0, 1, 2'b01, 4'd0, 8'hA5, 0); tick();
    drive(0, 1, 2'b10, 4'd5, 8'h00, 0); tick();
    chk3("rst_mid.start", 8'hA5, 1'b1, 1'b0);
    idle(); tick();
    chk3("rst_mid.shift1", 8'h52, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk3("rst_mid.async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk3($sformatf("rst_mid.after%0d", i), 8'h00, 1'b0, 1'b0);
    end

    // Start during a shift is dropped; clear aborts a shift with no done.
    drive(0, 1, 2'b01, 4'd0, 8'h5A, 0); tick();
    drive(0, 1, 2'b10, 4'd4, 8'h00, 0); tick();
    drive(0, 1, 2'b01, 4'd0, 8'hFF, 0); tick();
    chk3("coll.s1", 8'h2D, 1'b1, 1'b0);
    idle(); tick();
    chk3("coll.s2", 8'h16, 1'b1, 1'b0);
    tick(); chk3("coll.s3", 8'h0B, 1'b1, 1'b0);
    tick(); chk3("coll.s4", 8'h05, 1'b0, 1'b1);
    drive(0, 1, 2'b11, 4'd4, 8'h00, 1); tick();
    idle(); bus.serial_in = 1'b1; tick();
    chk3("clr.s1", 8'h82, 1'b1, 1'b0);
    drive(1, 0, 2'b00, 4'd0, 8'h00, 1); tick();
    chk3("clr.hit", 8'h00, 1'b0, 1'b0);
    idle(); tick();
    chk3("clr.after", 8'h00, 1'b0, 1'b0);

    // Random traffic against the reference model.
    m_q = bus.q; m_left = 0; m_or = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic         clr, st, sin;
      logic [1:0]   ch;
      logic [A-1:0] amt;
      logic [W-1:0] val;
      clr = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 2) == 0);
      ch  = 2'($urandom);
      amt = A'($urandom_range(0, 15));
      val = W'($urandom);
      sin = 1'($urandom);
      drive(clr, st, ch, amt, val, sin);
      model_edge(clr, st, ch, amt, val, sin);
      tick();
      chk3($sformatf("rnd%0d", i), m_q, (m_left > 0), m_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
